denise_colortable_ctrl: RTL

Write-side controller for the Denise 256×32 colour-table RAM. It decodes custom-register writes to COLOR00–COLOR31 and BPLCON3, and forms the AGA bank/LOCT address. LOCT low-nibble writes need a read-modify-write; for these it shares the RAM read port with the pixel lookup path. After reset it clears the whole table. It sits between the register bus and the dual-port colour-table RAM, and drives every RAM input except the pixel-side read data sink.

---
 rtl/denise_colortable_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/denise_colortable_ctrl.sv
// Write-side controller for the Denise 256x32 colour-table RAM.
// Decodes COLOR00-31 / BPLCON3 writes and queues colour updates.
// Runs LOCT read-modify-writes through a read port that it shares with the pixel path.
// Clears the whole table after reset.
module denise_colortable_ctrl #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned QDEPTH     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reg_wr,
  input  logic [7:0]  reg_addr,
  input  logic [15:0] reg_data,
  input  logic        pix_rd_req,
  input  logic [7:0]  pix_rd_addr,
  output logic        pix_hold,
  output logic        ram_enable,
  output logic [7:0]  ram_rdaddress,
  output logic [7:0]  ram_wraddress,
  output logic        ram_wren,
  output logic [3:0]  ram_byteena,
  output logic [31:0] ram_data,
  input  logic [31:0] ram_q,
  output logic        busy,
  output logic        overflow,
  output logic        clear_done
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_RD, S_WAIT, S_WR} state_e;

  typedef struct packed {
    logic [7:0]  addr;
    logic        loct;
    logic [11:0] rgb;
  } entry_t;

  state_e          state_q, state_d;
  logic [7:0]      clr_q, clr_d;
  logic [2:0]      bank_q, bank_d;
  logic            loct_q, loct_d;
  logic [SW-1:0]   starve_q, starve_d;
  entry_t          fifo_q [QDEPTH];
  entry_t          fifo_d [QDEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            overflow_q, overflow_d;
  logic            clear_done_q, clear_done_d;
  logic            wren_q, wren_d;
  logic [7:0]      wraddr_q, wraddr_d;
  logic [31:0]     data_q, data_d;

  logic   is_bpl, is_col, full, push, pop, starved, rd_grant;
  entry_t head;
  logic   unused_bits;

  assign is_bpl   = reg_wr && (reg_addr == 8'h83);
  assign is_col   = reg_wr && (reg_addr[7:5] == 3'b110);
  assign full     = (cnt_q == CW'(QDEPTH));
  assign pop      = (state_q == S_WR);
  // A full queue still accepts a push in the cycle its head is popped.
  assign push     = is_col && (!full || pop);
  assign head     = fifo_q[rd_ptr_q];
  assign starved  = (starve_q == SW'(STARVE_MAX));
  assign rd_grant = (state_q == S_RD) && (!pix_rd_req || starved);

  assign pix_hold      = (state_q == S_RD) && pix_rd_req && starved;
  assign ram_rdaddress = rd_grant ? head.addr : pix_rd_addr;
  assign ram_enable    = 1'b1;
  assign ram_byteena   = 4'b1111;
  assign ram_wren      = wren_q;
  assign ram_wraddress = wraddr_q;
  assign ram_data      = data_q;
  assign overflow      = overflow_q;
  assign clear_done    = clear_done_q;
  assign busy          = (cnt_q != '0) || (state_q != S_IDLE);
  assign unused_bits   = ^{ram_q[31:24], ram_q[19:16], ram_q[11:8], ram_q[3:0], reg_data[12]};

  always_comb begin
    bank_d     = bank_q;
    loct_d     = loct_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q | (is_col && full && !pop);

    if (is_bpl) begin
      bank_d = reg_data[15:13];
      loct_d = reg_data[9];
    end
    if (push) begin
      fifo_d[wr_ptr_q] = '{addr: {bank_q, reg_addr[4:0]}, loct: loct_q, rgb: reg_data[11:0]};
      wr_ptr_d = (wr_ptr_q == PW'(QDEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(QDEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    clr_d        = clr_q;
    starve_d     = starve_q;
    clear_done_d = clear_done_q;
    wren_d       = 1'b0;
    wraddr_d     = wraddr_q;
    data_d       = data_q;
    case (state_q)
      S_CLEAR: begin
        wren_d   = 1'b1;
        wraddr_d = clr_q;
        data_d   = '0;
        clr_d    = clr_q + 1'b1;
        if (clr_q == 8'hFF) state_d = S_IDLE;
      end
      S_IDLE: begin
        clear_done_d = 1'b1;
        if (cnt_q != '0) begin
          if (head.loct) begin
            state_d = S_RD;
          end else begin
            state_d  = S_WR;
            wren_d   = 1'b1;
            wraddr_d = head.addr;
            data_d   = {8'h00, head.rgb[11:8], head.rgb[11:8], head.rgb[7:4],
                        head.rgb[7:4], head.rgb[3:0], head.rgb[3:0]};
          end
        end
      end
      S_RD: begin
        if (rd_grant) begin
          state_d  = S_WAIT;
          starve_d = '0;
        end else begin
          starve_d = starve_q + 1'b1;
        end
      end
      S_WAIT: begin
        state_d  = S_WR;
        wren_d   = 1'b1;
        wraddr_d = head.addr;
        data_d   = {8'h00, ram_q[23:20], head.rgb[11:8], ram_q[15:12],
                    head.rgb[7:4], ram_q[7:4], head.rgb[3:0]};
      end
      S_WR:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_CLEAR;
      clr_q        <= '0;
      bank_q       <= '0;
      loct_q       <= 1'b0;
      starve_q     <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      overflow_q   <= 1'b0;
      clear_done_q <= 1'b0;
      wren_q       <= 1'b0;
      wraddr_q     <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      clr_q        <= clr_d;
      bank_q       <= bank_d;
      loct_q       <= loct_d;
      starve_q     <= starve_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      overflow_q   <= overflow_d;
      clear_done_q <= clear_done_d;
      wren_q       <= wren_d;
      wraddr_q     <= wraddr_d;
      data_q       <= data_d;
    end
  end

endmodule
